polar_avg: RTL and testbench

POLAR_AVG -- requirements
Module: polar_avg

---
 rtl/polar_avg_pkg.sv | 15 +
 rtl/polar_avg_if.sv | 26 ++
 rtl/polar_avg_phase_delta.sv | 28 ++
 rtl/polar_avg.sv | 133 +++++++++++++
 tb/tb_polar_avg.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/polar_avg_pkg.sv
// Shared types and default widths for the polar averaging block.
package polar_avg_pkg;

   localparam int MW       = 16;  // magnitude sample width
   localparam int PW       = 25;  // phase width, full circle = 2^PW
   localparam int LOGN_MAX = 10;  // largest log2 window length

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      ACCUM,
      DONE
   } state_e;

endpackage

// File: rtl/polar_avg_if.sv
// Sample stream, control and result signals of polar_avg.
interface polar_avg_if #(
   parameter int MW = polar_avg_pkg::MW,
   parameter int PW = polar_avg_pkg::PW
);
   logic                 i_ce;
   logic signed [MW-1:0] i_mag;
   logic [PW-1:0]        i_phase;
   logic                 i_start;
   logic                 i_abort;
   logic [3:0]           i_log_n;
   logic                 o_busy;
   logic                 o_valid;
   logic [MW-1:0]        o_mag_avg;
   logic signed [PW-1:0] o_dphi_avg;

   modport slave (
      input  i_ce, i_mag, i_phase, i_start, i_abort, i_log_n,
      output o_busy, o_valid, o_mag_avg, o_dphi_avg
   );

   modport master (
      output i_ce, i_mag, i_phase, i_start, i_abort, i_log_n,
      input  o_busy, o_valid, o_mag_avg, o_dphi_avg
   );
endinterface

// File: rtl/polar_avg_phase_delta.sv
// Holds the previous phase and yields the wrapped signed phase step.
module phase_delta #(
   parameter int PW = polar_avg_pkg::PW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_i,
   input  logic [PW-1:0]        phase_i,
   output logic signed [PW-1:0] dphi_o
);

   logic [PW-1:0] prev_q;

   // Capture the phase of every accepted sample as the next reference.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every register sees pre-edge values.
      if (rst) begin
         prev_q <= '0;
      end else if (load_i) begin
         prev_q <= phase_i;
      end
   end

   // PW-bit subtraction wraps modulo 2^PW; reading it signed gives the
   // shortest way round the circle.
   assign dphi_o = signed'(phase_i - prev_q);

endmodule

// File: rtl/polar_avg.sv
// Averages magnitude and per-sample phase increment over 2^n samples.
module polar_avg
   import polar_avg_pkg::*;
#(
   parameter int MW       = polar_avg_pkg::MW,
   parameter int PW       = polar_avg_pkg::PW,
   parameter int LOGN_MAX = polar_avg_pkg::LOGN_MAX
) (
   input logic         clk,
   input logic         rst,
   polar_avg_if.slave  bus
);

   localparam int MAW = MW + LOGN_MAX;  // magnitude accumulator width
   localparam int DAW = PW + LOGN_MAX;  // phase-step accumulator width
   localparam int CW  = LOGN_MAX + 1;   // sample counter width

   state_e                state_q, state_d;
   logic [3:0]            n_q, n_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [CW-1:0]         last_idx;
   logic [MAW-1:0]        mag_acc_q, mag_acc_d, mag_add;
   logic signed [DAW-1:0] dphi_acc_q, dphi_acc_d, dphi_add;
   logic [MW-1:0]         mag_avg_q, mag_avg_d;
   logic signed [PW-1:0]  dphi_avg_q, dphi_avg_d;
   logic                  valid_q, valid_d;
   logic                  pd_load;
   logic signed [PW-1:0]  dphi;

   phase_delta #(.PW(PW)) u_phase_delta (
      .clk     (clk),
      .rst     (rst),
      .load_i  (pd_load),
      .phase_i (bus.i_phase),
      .dphi_o  (dphi)
   );

   // Negative magnitudes contribute nothing; phase step is sign-extended.
   assign mag_add  = bus.i_mag[MW-1] ? '0 : {{LOGN_MAX{1'b0}}, bus.i_mag};
   assign dphi_add = {{LOGN_MAX{dphi[PW-1]}}, dphi};
   // Counter value of the last sample in the window: 2^n - 1.
   assign last_idx = (CW'(1) << n_q) - CW'(1);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Window parameters, accumulators and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         n_q        <= '0;
         cnt_q      <= '0;
         mag_acc_q  <= '0;
         dphi_acc_q <= '0;
         mag_avg_q  <= '0;
         dphi_avg_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         n_q        <= n_d;
         cnt_q      <= cnt_d;
         mag_acc_q  <= mag_acc_d;
         dphi_acc_q <= dphi_acc_d;
         mag_avg_q  <= mag_avg_d;
         dphi_avg_q <= dphi_avg_d;
         valid_q    <= valid_d;
      end
   end

   // Next-state and datapath update; abort outranks everything but reset.
   always_comb begin
      // NOTE: every output gets a hold/default value first so no latch is inferred.
      state_d    = state_q;
      n_d        = n_q;
      cnt_d      = cnt_q;
      mag_acc_d  = mag_acc_q;
      dphi_acc_d = dphi_acc_q;
      mag_avg_d  = mag_avg_q;
      dphi_avg_d = dphi_avg_q;
      valid_d    = 1'b0;
      pd_load    = 1'b0;

      if (bus.i_abort && state_q != IDLE) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.i_start) begin
                  n_d        = (bus.i_log_n > 4'(LOGN_MAX)) ? 4'(LOGN_MAX) : bus.i_log_n;
                  cnt_d      = '0;
                  mag_acc_d  = '0;
                  dphi_acc_d = '0;
                  state_d    = PRIME;
               end
            end
            PRIME: begin
               if (bus.i_ce) begin
                  pd_load = 1'b1;
                  state_d = ACCUM;
               end
            end
            ACCUM: begin
               if (bus.i_ce) begin
                  pd_load    = 1'b1;
                  mag_acc_d  = mag_acc_q + mag_add;
                  dphi_acc_d = dphi_acc_q + dphi_add;
                  cnt_d      = cnt_q + CW'(1);
                  if (cnt_q == last_idx) begin
                     state_d = DONE;
                  end
               end
            end
            DONE: begin
               mag_avg_d  = MW'(mag_acc_q >> n_q);
               dphi_avg_d = PW'(dphi_acc_q >>> n_q);
               valid_d    = 1'b1;
               state_d    = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.o_busy     = (state_q != IDLE);
   assign bus.o_valid    = valid_q;
   assign bus.o_mag_avg  = mag_avg_q;
   assign bus.o_dphi_avg = dphi_avg_q;

endmodule

// File: tb/tb_polar_avg.sv
// Directed, table-driven bench for polar_avg.
module tb_polar_avg;

   typedef struct packed {
      logic [3:0]  log_n;
      logic [7:0]  first;
      logic [7:0]  count;
      logic [15:0] exp_mag;
      logic [24:0] exp_dphi;
   } vec_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;

   vec_t               vecs [0:7];
   logic [24:0]        sph  [0:24];
   logic signed [15:0] smag [0:24];

   polar_avg_if #(.MW(16), .PW(25)) bus ();

   polar_avg dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Caller sits on a falling edge; one strobed sample, then strobe drops.
   task automatic feed(input logic signed [15:0] m, input logic [24:0] p);
      bus.i_ce    = 1'b1;
      bus.i_mag   = m;
      bus.i_phase = p;
      @(negedge clk);
      bus.i_ce    = 1'b0;
   endtask

   task automatic start(input logic [3:0] ln, input string tag);
      bus.i_start = 1'b1;
      bus.i_log_n = ln;
      @(negedge clk);
      bus.i_start = 1'b0;
      check({tag, ".busy_after_start"}, {31'b0, bus.o_busy}, 32'd1);
   endtask

   // Called on the falling edge right after the last sample was accepted.
   task automatic finish_checks(input string tag, input logic [15:0] em, input logic [24:0] ed);
      check({tag, ".done_busy"},  {31'b0, bus.o_busy},  32'd1);
      check({tag, ".done_valid"}, {31'b0, bus.o_valid}, 32'd0);
      @(negedge clk);
      check({tag, ".valid"}, {31'b0, bus.o_valid}, 32'd1);
      check({tag, ".busy"},  {31'b0, bus.o_busy},  32'd0);
      check({tag, ".mag"},   {16'b0, bus.o_mag_avg},  {16'b0, em});
      check({tag, ".dphi"},  {7'b0,  bus.o_dphi_avg}, {7'b0, ed});
      @(negedge clk);
      check({tag, ".valid_drop"}, {31'b0, bus.o_valid}, 32'd0);
      check({tag, ".mag_hold"},   {16'b0, bus.o_mag_avg},  {16'b0, em});
      check({tag, ".dphi_hold"},  {7'b0,  bus.o_dphi_avg}, {7'b0, ed});
   endtask

   task automatic run_vec(input int v);
      string tag;
      int    f;
      int    c;
      tag = $sformatf("vec%0d", v);
      f   = int'(vecs[v].first);
      c   = int'(vecs[v].count);
      start(vecs[v].log_n, tag);
      for (int s = 0; s < c; s++) begin
         feed(smag[f+s], sph[f+s]);
         if ((s % 2 == 1) && (s != c - 1)) @(negedge clk);  // idle gap must hold state
      end
      finish_checks(tag, vecs[v].exp_mag, vecs[v].exp_dphi);
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;

      // Flat sample pool; each vector takes a slice: PRIME sample then 2^n samples.
      sph = '{25'h0000000, 25'h0000100, 25'h0000200, 25'h0000300, 25'h0000400,
              25'h1FFFF00, 25'h0000100, 25'h0000300,
              25'h0000300, 25'h0000100, 25'h1FFFF00,
              25'h0000010, 25'h1FFFFF0,
              25'h1FFFFF0, 25'h0000010,
              25'h0000000, 25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFF,
              25'h0000000, 25'h0000005, 25'h000000A,
              25'h0000100, 25'h0000140};
      smag = '{16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000,
               16'sd10, 16'sd20, 16'sd31,
               -16'sd5, -16'sd100, 16'sd7,
               16'sd1, 16'sd77,
               16'sd0, 16'sh7FFF,
               16'sd0, 16'sd3, 16'sd3, 16'sd3, 16'sd2,
               16'sd0, -16'sd32768, 16'sh7FFF,
               16'sd9, 16'sd9};
      vecs = '{'{4'd2, 8'd0,  8'd5, 16'd1000,   25'h0000100},  // basic mean
               '{4'd1, 8'd5,  8'd3, 16'd25,     25'h0000200},  // wrap forward, mag truncates
               '{4'd1, 8'd8,  8'd3, 16'd3,      25'h1FFFE00},  // wrap backward, negative mag dropped
               '{4'd0, 8'd11, 8'd2, 16'd77,     25'h1FFFFE0},  // n=0, -0x20 step
               '{4'd0, 8'd13, 8'd2, 16'h7FFF,   25'h0000020},  // n=0, +0x20 step
               '{4'd2, 8'd15, 8'd5, 16'd2,      25'h1FFFFFF},  // -1/4 floors to -1
               '{4'd1, 8'd20, 8'd3, 16'h3FFF,   25'h0000005},  // most negative mag dropped
               '{4'd0, 8'd23, 8'd2, 16'd9,      25'h0000040}}; // after abort

      rst         = 1'b1;
      bus.i_ce    = 1'b0;
      bus.i_mag   = '0;
      bus.i_phase = '0;
      bus.i_start = 1'b0;
      bus.i_abort = 1'b0;
      bus.i_log_n = '0;
      repeat (3) @(negedge clk);
      check("reset.busy",  {31'b0, bus.o_busy},  32'd0);
      check("reset.valid", {31'b0, bus.o_valid}, 32'd0);
      check("reset.mag",   {16'b0, bus.o_mag_avg},  32'd0);
      check("reset.dphi",  {7'b0,  bus.o_dphi_avg}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 7; v++) begin
         run_vec(v);
      end

      // Abort mid-ACCUM with a simultaneous strobe: back to IDLE, results untouched.
      start(4'd3, "abort");
      feed(16'sd50, 25'h0);
      for (int k = 1; k <= 4; k++) feed(16'sd50, 25'(k * 'h10));
      bus.i_abort = 1'b1;
      bus.i_ce    = 1'b1;
      bus.i_mag   = 16'sd50;
      bus.i_phase = 25'h50;
      @(negedge clk);
      bus.i_abort = 1'b0;
      bus.i_ce    = 1'b0;
      check("abort.busy",  {31'b0, bus.o_busy},  32'd0);
      check("abort.valid", {31'b0, bus.o_valid}, 32'd0);
      check("abort.mag",   {16'b0, bus.o_mag_avg},  32'h3FFF);
      check("abort.dphi",  {7'b0,  bus.o_dphi_avg}, 32'h5);
      @(negedge clk);
      check("abort.valid_later", {31'b0, bus.o_valid}, 32'd0);
      run_vec(7);

      // Start while busy must be ignored; window completes with n=1.
      start(4'd1, "busy_start");
      feed(16'sd0, 25'h00);
      feed(16'sd4, 25'h30);
      bus.i_start = 1'b1;
      bus.i_log_n = 4'd0;
      feed(16'sd6, 25'h50);
      bus.i_start = 1'b0;
      finish_checks("busy_start", 16'd5, 25'h28);

      // Reset mid-ACCUM, together with a start: everything clears.
      start(4'd2, "rst_mid");
      feed(16'sd100, 25'h0);
      feed(16'sd100, 25'h10);
      feed(16'sd100, 25'h20);
      rst         = 1'b1;
      bus.i_start = 1'b1;
      @(negedge clk);
      check("rst_mid.busy",  {31'b0, bus.o_busy},  32'd0);
      check("rst_mid.valid", {31'b0, bus.o_valid}, 32'd0);
      check("rst_mid.mag",   {16'b0, bus.o_mag_avg},  32'd0);
      check("rst_mid.dphi",  {7'b0,  bus.o_dphi_avg}, 32'd0);
      rst         = 1'b0;
      bus.i_start = 1'b0;
      @(negedge clk);
      check("rst_mid.busy_after", {31'b0, bus.o_busy}, 32'd0);

      // log_n=15 clamps to 10: prime + 1024 full-scale samples, wrapping phase.
      start(4'd15, "clamp");
      for (int i = 0; i <= 1024; i++) begin
         if (i == 1024) begin
            check("clamp.busy_before_last",  {31'b0, bus.o_busy},  32'd1);
            check("clamp.valid_before_last", {31'b0, bus.o_valid}, 32'd0);
         end
         feed(16'sh7FFF, 25'(i * 'h90000));
      end
      finish_checks("clamp", 16'h7FFF, 25'h0090000);

      // Abort during DONE: no result strobe, previous results kept.
      start(4'd0, "abort_done");
      feed(16'sd3, 25'h0);
      feed(16'sd8, 25'h10);
      check("abort_done.in_done", {31'b0, bus.o_busy}, 32'd1);
      bus.i_abort = 1'b1;
      @(negedge clk);
      bus.i_abort = 1'b0;
      check("abort_done.valid", {31'b0, bus.o_valid}, 32'd0);
      check("abort_done.busy",  {31'b0, bus.o_busy},  32'd0);
      check("abort_done.mag",   {16'b0, bus.o_mag_avg},  32'h7FFF);
      check("abort_done.dphi",  {7'b0,  bus.o_dphi_avg}, 32'h90000);
      @(negedge clk);
      check("abort_done.valid_later", {31'b0, bus.o_valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
